// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axi_rd_arbiter
// Round-robin sharing of one AXI read engine between NUM_REQ requesters,
// one burst outstanding at a time, with a per-burst watchdog.
// Rev    : 1.0
// ============================================================================
module axi_rd_arbiter #(
    parameter int NUM_REQ            = 3,
    parameter int BURST_LENGTH_WIDTH = 8,
    parameter int BURST_SIZE_WIDTH   = 3,
    parameter int ADDRESS_WIDTH      = 19,
    parameter int TIMEOUT_CYCLES     = 4096
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ*BURST_LENGTH_WIDTH-1:0] req_len,
    input  logic [NUM_REQ*BURST_SIZE_WIDTH-1:0]   req_size,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]      req_addr,
    output logic [NUM_REQ-1:0]                    grant,
    output logic [NUM_REQ-1:0]                    done,
    output logic                                  timeout_err,
    output logic                                  busy,
    output logic                                  init_read,
    output logic [BURST_LENGTH_WIDTH-1:0]         read_burst_length,
    output logic [BURST_SIZE_WIDTH-1:0]           read_burst_size,
    output logic [ADDRESS_WIDTH-1:0]              read_start_address,
    input  logic                                  rx_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   winner;
    logic               found;
    int                 scan_idx;
    logic [CNT_W-1:0]   wait_cnt;
    logic               aborted;
    logic               wd_expired;

    // Scan upward from the pointer, wrapping, and keep the first active request.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(ptr) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!found && req[IDX_W'(scan_idx)]) begin
                found  = 1'b1;
                winner = IDX_W'(scan_idx);
            end
        end
    end

    assign wd_expired = (TIMEOUT_CYCLES != 0) &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        init_read   = 1'b0;
        busy        = 1'b1;
        done        = '0;
        timeout_err = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (found) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                init_read  = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the same cycle as expiry wins over the abort.
                if (rx_done || wd_expired) begin
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                done        = grant;
                timeout_err = aborted;
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant              <= '0;
            owner              <= '0;
            ptr                <= '0;
            wait_cnt           <= '0;
            aborted            <= 1'b0;
            read_burst_length  <= '0;
            read_burst_size    <= '0;
            read_start_address <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant              <= NUM_REQ'(1) << winner;
                        owner              <= winner;
                        read_burst_length  <= req_len[int'(winner)*BURST_LENGTH_WIDTH +: BURST_LENGTH_WIDTH];
                        read_burst_size    <= req_size[int'(winner)*BURST_SIZE_WIDTH +: BURST_SIZE_WIDTH];
                        read_start_address <= req_addr[int'(winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    aborted  <= 1'b0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (!rx_done && wd_expired) begin
                        aborted <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    grant <= '0;
                    ptr   <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// Testbench for axi_rd_arbiter: randomized requesters and read-engine responder,
// round-robin reference model feeding a scoreboard checked by a monitor.
module tb_axi_rd_arbiter;

    localparam int N  = 3;
    localparam int LW = 8;
    localparam int SW = 3;
    localparam int AW = 19;
    localparam int TO = 12;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*LW-1:0] req_len;
    logic [N*SW-1:0] req_size;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            timeout_err;
    logic            busy;
    logic            init_read;
    logic [LW-1:0]   read_burst_length;
    logic [SW-1:0]   read_burst_size;
    logic [AW-1:0]   read_start_address;
    logic            rx_done;

    logic [LW-1:0] len_a  [N];
    logic [SW-1:0] size_a [N];
    logic [AW-1:0] addr_a [N];

    always_comb begin
        req_len  = '0;
        req_size = '0;
        req_addr = '0;
        for (int i = 0; i < N; i++) begin
            req_len[i*LW +: LW]  = len_a[i];
            req_size[i*SW +: SW] = size_a[i];
            req_addr[i*AW +: AW] = addr_a[i];
        end
    end

    axi_rd_arbiter #(
        .NUM_REQ(N), .BURST_LENGTH_WIDTH(LW), .BURST_SIZE_WIDTH(SW),
        .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_size(req_size),
        .req_addr(req_addr), .grant(grant), .done(done), .timeout_err(timeout_err),
        .busy(busy), .init_read(init_read), .read_burst_length(read_burst_length),
        .read_burst_size(read_burst_size), .read_start_address(read_start_address),
        .rx_done(rx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  g;
        logic [LW-1:0] len;
        logic [SW-1:0] size;
        logic [AW-1:0] addr;
    } grant_t;

    typedef struct {
        logic [N-1:0] d;
        logic         to;
        int           lat;
    } done_t;

    grant_t exp_g[$];
    done_t  exp_d[$];

    int n_pass  = 0;
    int n_total = 0;
    int model_ptr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act !== expv) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Round-robin rule: first requester at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (p + i) % N;
            if (((r >> k) & 1) != 0) return k;
        end
        return -1;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT starts or finishes a burst.
    int   cyc = 0;
    int   init_cyc = 0;
    logic prev_init = 1'b0;
    logic after_done = 1'b0;

    always @(negedge clk) begin
        grant_t g;
        done_t  e;
        cyc++;
        if (after_done) chk("busy_after_done", busy, 0);
        after_done = 1'b0;
        chk("grant_onehot0", $onehot0(grant), 1);
        chk("done_subset_grant", |(done & ~grant), 0);
        chk("err_without_done", timeout_err && (done == '0), 0);
        if (init_read) begin
            chk("init_single_cycle", prev_init, 0);
            if (exp_g.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_init: got init_read=1 expected no burst");
            end else begin
                g = exp_g.pop_front();
                chk("grant", grant, g.g);
                chk("burst_len", read_burst_length, g.len);
                chk("burst_size", read_burst_size, g.size);
                chk("burst_addr", read_start_address, g.addr);
                chk("busy_in_issue", busy, 1);
            end
            init_cyc = cyc;
        end
        prev_init = init_read;
        if (done != '0) begin
            if (exp_d.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=%0h expected none", done);
            end else begin
                e = exp_d.pop_front();
                chk("done", done, e.d);
                chk("timeout_err", timeout_err, e.to);
                chk("done_latency", cyc - init_cyc, e.lat);
            end
            after_done = 1'b1;
        end
    end

    task automatic raise(input int i);
        if (req[i] == 1'b0) begin
            req[i]    = 1'b1;
            len_a[i]  = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom);
            size_a[i] = SW'($urandom);
            addr_a[i] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
        end
    endtask

    // d >= 0: rx_done in the (d+1)th WAIT cycle; d < 0: never, watchdog fires.
    // Called at a negedge with req final; returns at the negedge of the IDLE cycle.
    task automatic run_burst(input int d, input bit drop_owner, input bit noise);
        int     w;
        grant_t g;
        done_t  e;
        bit     seen;
        w = rr_pick(req, model_ptr);
        if (w < 0) return;
        g.g = N'(1) << w;
        g.len = len_a[w];
        g.size = size_a[w];
        g.addr = addr_a[w];
        exp_g.push_back(g);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            seen = init_read;
        end
        if (!seen) begin
            n_total++;
            $display("FAIL init_wait: got no init_read within 8 cycles expected one");
            return;
        end
        if (noise) rx_done = 1'($urandom_range(0, 1));
        e.d   = g.g;
        e.to  = (d < 0);
        e.lat = (d < 0) ? TO + 1 : d + 2;
        exp_d.push_back(e);
        for (int c = 1; c <= e.lat; c++) begin
            @(negedge clk);
            rx_done = (d >= 0) && (c == d + 1);
            if (c == e.lat) begin
                if (drop_owner) req[w] = 1'b0;
            end else if (noise) begin
                if ($urandom_range(0, 3) == 0) raise((w + 1 + $urandom_range(0, N - 2)) % N);
                if ($urandom_range(0, 4) == 0) begin
                    len_a[w]  = LW'($urandom);
                    size_a[w] = SW'($urandom);
                    addr_a[w] = AW'($urandom);
                end
                if (drop_owner && $urandom_range(0, 9) == 0) req[w] = 1'b0;
            end
        end
        model_ptr = (w + 1) % N;
        @(negedge clk);
        rx_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic set_req(input int i, input logic [LW-1:0] l, input logic [SW-1:0] s,
                           input logic [AW-1:0] a);
        req[i] = 1'b1;
        len_a[i] = l;
        size_a[i] = s;
        addr_a[i] = a;
    endtask

    initial begin
        grant_t g;
        int     d;
        rst = 1'b1;
        req = '0;
        rx_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            len_a[i] = '0; size_a[i] = '0; addr_a[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_init", init_read, 0);
        chk("rst_len", read_burst_length, 0);
        rst = 1'b0;
        @(negedge clk);

        // all three held: order 001,010,100,001
        set_req(0, 8'd1, 3'd2, 19'h11);
        set_req(1, 8'd2, 3'd3, 19'h22);
        set_req(2, 8'd3, 3'd4, 19'h33);
        for (int b = 0; b < 4; b++) run_burst(b, 1'b0, 1'b0);
        req = '0;
        @(negedge clk);

        // single burst, rx_done 10 cycles after init
        set_req(0, 8'd15, 3'd6, 19'h100);
        run_burst(9, 1'b1, 1'b0);

        // 101 with pointer at 1: 100 then 001
        set_req(0, 8'd0, 3'd0, 19'h0);
        set_req(2, 8'd7, 3'd1, 19'h7ffff);
        run_burst(0, 1'b1, 1'b0);
        run_burst(TO - 1, 1'b1, 1'b0);

        // stray rx_done while idle, then watchdog abort
        repeat (2) begin
            @(negedge clk);
            rx_done = 1'b1;
        end
        @(negedge clk);
        rx_done = 1'b0;
        set_req(1, 8'd5, 3'd5, 19'h555);
        run_burst(-1, 1'b1, 1'b1);

        // randomized traffic
        for (int b = 0; b < 40; b++) begin
            if (req == '0 && $urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    rx_done = 1'($urandom_range(0, 1));
                end
            end
            if ($urandom_range(0, 2) == 0) raise($urandom_range(0, N - 1));
            while (req == '0) raise($urandom_range(0, N - 1));
            case ($urandom_range(0, 9))
                0:       d = -1;
                1:       d = TO - 1;
                default: d = $urandom_range(0, TO - 1);
            endcase
            run_burst(d, ($urandom_range(0, 3) != 0), 1'b1);
        end

        // reset mid-WAIT, pointer parked at 1 beforehand
        req = '0;
        rx_done = 1'b0;
        @(negedge clk);
        set_req(0, 8'd9, 3'd1, 19'h9);
        run_burst(2, 1'b1, 1'b0);
        req = '0;
        set_req(1, 8'd4, 3'd2, 19'h44);
        g.g = 3'b010; g.len = 8'd4; g.size = 3'd2; g.addr = 19'h44;
        exp_g.push_back(g);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_grant", grant, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", timeout_err, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_init", init_read, 0);
        chk("midrst_params", {read_burst_length, read_burst_size, read_start_address}, 0);
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        @(negedge clk);
        set_req(0, 8'd1, 3'd1, 19'h1);
        set_req(1, 8'd2, 3'd2, 19'h2);
        set_req(2, 8'd3, 3'd3, 19'h3);
        run_burst(1, 1'b1, 1'b0);
        req = '0;
        set_req(1, 8'd6, 3'd6, 19'h66);
        run_burst(3, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        chk("sb_grant_empty", exp_g.size(), 0);
        chk("sb_done_empty", exp_d.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL time_limit: got no completion expected finish before limit");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
